// File: rtl/pvr_pcache_pkg.sv
// rtl/pvr_pcache_pkg.sv - shared parameters and requester ids for the primitive parameter cache controller
package pvr_pcache_pkg;

  localparam int TAG_W        = 12;
  localparam int ENTRIES      = 1024;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 11;
  localparam int SC_W         = 4;

  typedef enum logic [1:0] {
    REQ_WR,
    REQ_RD0,
    REQ_RD1,
    REQ_NONE
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a preferred-requester pointer
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // A lone requester always wins; on contention the pointer picks. After a
  // granted cycle the pointer moves to the requester that did not win.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register, 0 prefers requester 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pcache_ctrl.sv
// rtl/pcache_ctrl.sv - tag allocator and single-port arbiter for the primitive parameter cache
module pcache_ctrl
  import pvr_pcache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_req,
  output logic             wr_ack,
  output logic [TAG_W-1:0] wr_tag,
  output logic             full,
  output logic [10:0]      count,
  input  logic             rd0_req,
  input  logic [TAG_W-1:0] rd0_tag,
  output logic             rd0_gnt,
  output logic             rd0_valid,
  output logic             rd0_oob,
  input  logic             rd1_req,
  input  logic [TAG_W-1:0] rd1_tag,
  output logic             rd1_gnt,
  output logic             rd1_valid,
  output logic             rd1_oob,
  output logic             pcache_write,
  output logic [TAG_W-1:0] prim_tag
);

  logic [CNT_W-1:0] next_tag_q, next_tag_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             rd0_valid_q, rd0_oob_q, rd1_valid_q, rd1_oob_q;
  logic [1:0]       arb_gnt;
  logic             rd_pend, full_w, force_rd;
  req_id_t          sel;

  rr_arb2 u_rr_arb2 (
    .clock (clock),
    .reset (reset),
    .req_i ({rd1_req, rd0_req}),
    .adv_i (rd0_gnt | rd1_gnt),
    .gnt_o (arb_gnt)
  );

  // Pick the single owner of the address port this cycle. A reader starved by
  // a run of writes is forced through ahead of the writer; flush and full
  // block the writer but never the readers. Nothing is granted during reset.
  always_comb begin
    rd_pend  = rd0_req | rd1_req;
    full_w   = (next_tag_q == CNT_W'(ENTRIES));
    force_rd = (starve_q == SC_W'(STARVE_LIMIT)) && rd_pend;
    sel      = REQ_NONE;
    if (!reset) begin
      if (wr_req && !full_w && !flush && !force_rd) begin
        sel = REQ_WR;
      end else if (arb_gnt[0]) begin
        sel = REQ_RD0;
      end else if (arb_gnt[1]) begin
        sel = REQ_RD1;
      end
    end
  end

  // Drive grants and the cache address from the selected owner.
  always_comb begin
    wr_ack       = (sel == REQ_WR);
    rd0_gnt      = (sel == REQ_RD0);
    rd1_gnt      = (sel == REQ_RD1);
    pcache_write = wr_ack;
    case (sel)
      REQ_WR:  prim_tag = TAG_W'(next_tag_q);
      REQ_RD0: prim_tag = rd0_tag;
      REQ_RD1: prim_tag = rd1_tag;
      default: prim_tag = '0;
    endcase
  end

  // Allocator and starvation counter next state. The tag counter stops at
  // ENTRIES because the write is never accepted once full.
  always_comb begin
    next_tag_d = next_tag_q;
    if (flush) begin
      next_tag_d = '0;
    end else if (wr_ack) begin
      next_tag_d = next_tag_q + CNT_W'(1);
    end
    starve_d = '0;
    if (rd_pend && wr_ack) begin
      starve_d = force_rd ? starve_q
               : (starve_q == SC_W'(STARVE_LIMIT)) ? starve_q : starve_q + SC_W'(1);
    end
  end

  // State registers: allocator, starvation counter and the read-return pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_tag_q  <= '0;
      starve_q    <= '0;
      rd0_valid_q <= 1'b0;
      rd0_oob_q   <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd1_oob_q   <= 1'b0;
    end else begin
      next_tag_q  <= next_tag_d;
      starve_q    <= starve_d;
      rd0_valid_q <= rd0_gnt;
      rd0_oob_q   <= rd0_gnt && (rd0_tag >= TAG_W'(next_tag_q));
      rd1_valid_q <= rd1_gnt;
      rd1_oob_q   <= rd1_gnt && (rd1_tag >= TAG_W'(next_tag_q));
    end
  end

  assign wr_tag    = TAG_W'(next_tag_q);
  assign full      = full_w;
  assign count     = next_tag_q;
  assign rd0_valid = rd0_valid_q;
  assign rd0_oob   = rd0_oob_q;
  assign rd1_valid = rd1_valid_q;
  assign rd1_oob   = rd1_oob_q;

endmodule

// File: tb/tb_pcache_ctrl.sv
// tb/tb_pcache_ctrl.sv - self-checking bench for pcache_ctrl against a behavioural model
module tb_pcache_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        wr_req = 1'b0;
  logic        wr_ack;
  logic [11:0] wr_tag;
  logic        full;
  logic [10:0] count;
  logic        rd0_req = 1'b0;
  logic [11:0] rd0_tag = '0;
  logic        rd0_gnt, rd0_valid, rd0_oob;
  logic        rd1_req = 1'b0;
  logic [11:0] rd1_tag = '0;
  logic        rd1_gnt, rd1_valid, rd1_oob;
  logic        pcache_write;
  logic [11:0] prim_tag;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  int m_ntag, m_pref, m_starve;
  logic m_v0, m_o0, m_v1, m_o1;
  // expectations for the current cycle
  logic e_wack, e_g0, e_g1, e_rdp;
  logic [11:0] e_prim;

  wire [43:0] obs_vec = {wr_ack, wr_tag, full, count, rd0_gnt, rd0_valid, rd0_oob,
                         rd1_gnt, rd1_valid, rd1_oob, pcache_write, prim_tag};
  logic [43:0] exp_vec;

  pcache_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_tag(wr_tag), .full(full), .count(count),
    .rd0_req(rd0_req), .rd0_tag(rd0_tag), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_oob(rd0_oob),
    .rd1_req(rd1_req), .rd1_tag(rd1_tag), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_oob(rd1_oob),
    .pcache_write(pcache_write), .prim_tag(prim_tag)
  );

  always #5 clock = ~clock;

  task automatic set_in(input logic wr, input logic fl, input logic r0, input int t0,
                        input logic r1, input int t1);
    wr_req = wr; flush = fl;
    rd0_req = r0; rd0_tag = 12'(t0);
    rd1_req = r1; rd1_tag = 12'(t1);
  endtask

  task automatic model_reset;
    m_ntag = 0; m_pref = 0; m_starve = 0;
    m_v0 = 0; m_o0 = 0; m_v1 = 0; m_o1 = 0;
  endtask

  // Wait to the falling edge and derive this cycle's expected outputs from the arbitration rules.
  task automatic predict;
    logic starved;
    @(negedge clock);
    e_rdp   = rd0_req | rd1_req;
    starved = (m_starve >= 8) && e_rdp;
    e_wack  = wr_req && (m_ntag < 1024) && !flush && !starved;
    e_g0 = 0; e_g1 = 0;
    if (!e_wack && e_rdp) begin
      if (rd0_req && rd1_req) begin
        if (m_pref == 0) e_g0 = 1; else e_g1 = 1;
      end else if (rd0_req) e_g0 = 1;
      else e_g1 = 1;
    end
    e_prim = e_wack ? 12'(m_ntag) : e_g0 ? rd0_tag : e_g1 ? rd1_tag : 12'd0;
    exp_vec = {e_wack, 12'(m_ntag), (m_ntag == 1024), 11'(m_ntag), e_g0, m_v0, m_o0,
               e_g1, m_v1, m_o1, e_wack, e_prim};
  endtask

  // Advance past the rising edge and update the model.
  task automatic commit;
    @(posedge clock);
    #1;
    m_v0 = e_g0; m_o0 = e_g0 && (int'(rd0_tag) >= m_ntag);
    m_v1 = e_g1; m_o1 = e_g1 && (int'(rd1_tag) >= m_ntag);
    if (flush) m_ntag = 0;
    else if (e_wack) m_ntag = m_ntag + 1;
    if (e_g0) m_pref = 1;
    if (e_g1) m_pref = 0;
    if (e_rdp && e_wack) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
    else m_starve = 0;
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset;
    reset = 1;
    set_in(1, 0, 1, 3, 1, 4);
    @(negedge clock);
    n_chk++; if (obs_vec !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec); end
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 0;
    model_reset();
    predict();
    n_chk++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL post_reset: got %h want %h", obs_vec, exp_vec); end
    commit();
  endtask

  task automatic test_writes;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      predict();
      n_chk++;
      if ({wr_ack, pcache_write, wr_tag, prim_tag} !== {1'b1, 1'b1, 12'(i), 12'(i)}) begin
        n_fail++; $display("FAIL write_%0d: ack=%b we=%b tag=%0d prim=%0d want 1 1 %0d %0d",
                            i, wr_ack, pcache_write, wr_tag, prim_tag, i, i);
      end
      commit();
    end
    set_in(0, 0, 0, 0, 0, 0);
    predict();
    n_chk++; if (count !== 11'd3 || pcache_write !== 1'b0) begin n_fail++; $display("FAIL write_count: count=%0d we=%b want 3 0", count, pcache_write); end
    commit();
  endtask

  task automatic test_read_oob;
    set_in(0, 0, 1, 1, 0, 0);
    predict();
    n_chk++; if (rd0_gnt !== 1'b1 || prim_tag !== 12'd1) begin n_fail++; $display("FAIL rd0_grant: gnt=%b prim=%0d want 1 1", rd0_gnt, prim_tag); end
    commit();
    set_in(0, 0, 1, 5, 0, 0);
    predict();
    n_chk++; if ({rd0_valid, rd0_oob} !== 2'b10) begin n_fail++; $display("FAIL rd0_inrange: valid/oob=%b want 10", {rd0_valid, rd0_oob}); end
    n_chk++; if (rd0_gnt !== 1'b1 || prim_tag !== 12'd5) begin n_fail++; $display("FAIL rd0_grant5: gnt=%b prim=%0d want 1 5", rd0_gnt, prim_tag); end
    commit();
    set_in(0, 0, 0, 0, 0, 0);
    predict();
    n_chk++; if ({rd0_valid, rd0_oob} !== 2'b11) begin n_fail++; $display("FAIL rd0_oob: valid/oob=%b want 11", {rd0_valid, rd0_oob}); end
    commit();
    predict();
    n_chk++; if ({rd0_valid, rd0_oob} !== 2'b00) begin n_fail++; $display("FAIL rd0_pulse: valid/oob=%b want 00", {rd0_valid, rd0_oob}); end
    commit();
  endtask

  task automatic test_rr;
    logic [1:0] prev;
    do_reset();
    prev = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_in(0, 0, 1, 7, 1, 9); else set_in(0, 0, 0, 0, 0, 0);
      predict();
      if (i < 4) begin
        n_chk++;
        if ({rd1_gnt, rd0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL rr_grant_%0d: rd1/rd0 gnt=%b", i, {rd1_gnt, rd0_gnt});
        end
      end
      if (i > 0) begin
        n_chk++;
        if ({rd1_valid, rd0_valid} !== prev) begin
          n_fail++; $display("FAIL rr_valid_%0d: got %b want %b", i, {rd1_valid, rd0_valid}, prev);
        end
      end
      prev = {rd1_gnt, rd0_gnt};
      commit();
    end
  endtask

  task automatic test_starve;
    for (int i = 0; i < 18; i++) begin
      set_in(1, 0, 0, 0, 1, 2);
      predict();
      n_chk++;
      if (i == 8 || i == 17) begin
        if ({wr_ack, rd1_gnt, prim_tag} !== {1'b0, 1'b1, 12'd2}) begin
          n_fail++; $display("FAIL starve_force_%0d: ack=%b rd1_gnt=%b prim=%0d want 0 1 2", i, wr_ack, rd1_gnt, prim_tag);
        end
      end else if ({wr_ack, rd1_gnt} !== 2'b10) begin
        n_fail++; $display("FAIL starve_write_%0d: ack=%b rd1_gnt=%b want 1 0", i, wr_ack, rd1_gnt);
      end
      commit();
    end
    set_in(0, 0, 0, 0, 0, 0);
    predict();
    commit();
  endtask

  task automatic test_full_flush;
    int guard;
    guard = 0;
    while (m_ntag < 1024 && guard < 1100) begin
      set_in(1, 0, 0, 0, 0, 0);
      predict();
      n_chk++; if (wr_ack !== 1'b1 || wr_tag !== 12'(m_ntag)) begin n_fail++; $display("FAIL fill_%0d: ack=%b tag=%0d", m_ntag, wr_ack, wr_tag); end
      commit();
      guard++;
    end
    set_in(1, 0, 0, 0, 0, 0);
    predict();
    n_chk++; if ({full, count} !== {1'b1, 11'd1024}) begin n_fail++; $display("FAIL full_flag: full=%b count=%0d want 1 1024", full, count); end
    n_chk++; if ({wr_ack, pcache_write} !== 2'b00) begin n_fail++; $display("FAIL full_noack: ack=%b we=%b want 0 0", wr_ack, pcache_write); end
    commit();
    set_in(0, 1, 0, 0, 0, 0);
    predict();
    commit();
    set_in(0, 0, 0, 0, 0, 0);
    predict();
    n_chk++; if ({full, count, wr_tag} !== {1'b0, 11'd0, 12'd0}) begin n_fail++; $display("FAIL flush_clear: full=%b count=%0d tag=%0d want 0 0 0", full, count, wr_tag); end
    commit();
  endtask

  task automatic test_flush_write;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 0); predict(); commit();
    end
    set_in(1, 1, 1, 0, 0, 0);
    predict();
    n_chk++; if ({wr_ack, rd0_gnt} !== 2'b01) begin n_fail++; $display("FAIL flush_write: ack=%b rd0_gnt=%b want 0 1", wr_ack, rd0_gnt); end
    commit();
    set_in(0, 0, 0, 0, 0, 0);
    predict();
    n_chk++; if ({count, rd0_valid, rd0_oob} !== {11'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush_after: count=%0d valid=%b oob=%b want 0 1 0", count, rd0_valid, rd0_oob); end
    commit();
  endtask

  task automatic test_reset_mid_read;
    set_in(0, 0, 1, 2, 0, 0);
    predict();
    n_chk++; if (rd0_gnt !== 1'b1) begin n_fail++; $display("FAIL midrd_grant: gnt=%b want 1", rd0_gnt); end
    @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    n_chk++; if (obs_vec !== '0) begin n_fail++; $display("FAIL midrd_reset: got %h want 0", obs_vec); end
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      predict();
      n_chk++; if (rd0_valid !== 1'b0 || obs_vec !== exp_vec) begin n_fail++; $display("FAIL midrd_release_%0d: got %h want %h", i, obs_vec, exp_vec); end
      commit();
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 40, int'($urandom_range(0, 300)),
             $urandom_range(0, 99) < 40, int'($urandom_range(0, 300)));
      predict();
      n_chk++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs_vec, exp_vec); end
      commit();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_writes();
    test_read_oob();
    test_rr();
    test_starve();
    test_full_flush();
    test_flush_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
